// File: rtl/adc_sample_averager.sv
// Windowed averager for ADC conversion results: sums 2^LOG2_AVG same-channel
// samples and presents average, minimum and maximum on a valid/ready port.
module adc_sample_averager #(
  parameter int DATA_W   = 12,
  parameter int CH_W     = 3,
  parameter int LOG2_AVG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]   in_ch,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_avg,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
  output logic [CH_W-1:0]   out_ch,
  output logic              restart,
  output logic              overrun
);

  localparam int ACC_W = DATA_W + LOG2_AVG;
  localparam int CNT_W = LOG2_AVG + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_AVG) - 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [CH_W-1:0]   cur_ch;
  logic [DATA_W-1:0] run_min;
  logic [DATA_W-1:0] run_max;

  logic [ACC_W-1:0]  sum_next;
  logic [DATA_W-1:0] min_next;
  logic [DATA_W-1:0] max_next;
  logic              same_ch;
  logic              win_done;
  logic              can_load;

  // Final window values include the completing sample itself.
  assign sum_next = acc + ACC_W'(in_data);
  assign min_next = (in_data < run_min) ? in_data : run_min;
  assign max_next = (in_data > run_max) ? in_data : run_max;
  assign same_ch  = (in_ch == cur_ch);
  assign win_done = !clear && in_valid && (state == ACCUM) && same_ch && (cnt == LAST_CNT);
  assign can_load = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      cur_ch    <= '0;
      run_min   <= '0;
      run_max   <= '0;
      out_valid <= 1'b0;
      out_avg   <= '0;
      out_min   <= '0;
      out_max   <= '0;
      out_ch    <= '0;
      restart   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      restart <= 1'b0;

      // A completion on the same edge as an accept replaces the result with no gap.
      if (win_done && can_load) begin
        out_valid <= 1'b1;
        out_avg   <= DATA_W'(sum_next >> LOG2_AVG);
        out_min   <= min_next;
        out_max   <= max_next;
        out_ch    <= cur_ch;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (win_done && !can_load)
        overrun <= 1'b1;

      if (clear) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (in_valid) begin
        case (state)
          IDLE: begin
            acc     <= ACC_W'(in_data);
            run_min <= in_data;
            run_max <= in_data;
            cur_ch  <= in_ch;
            cnt     <= CNT_W'(1);
            state   <= ACCUM;
          end
          ACCUM: begin
            if (!same_ch) begin
              acc     <= ACC_W'(in_data);
              run_min <= in_data;
              run_max <= in_data;
              cur_ch  <= in_ch;
              cnt     <= CNT_W'(1);
              restart <= 1'b1;
            end else if (win_done) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              acc     <= sum_next;
              run_min <= min_next;
              run_max <= max_next;
              cnt     <= cnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/adc_sample_averager.md
Name: adc_sample_averager

Overview:
- Downstream consumer of the SPI ADC front end.
- Takes one 12-bit conversion result plus its channel tag per valid pulse.
- Accumulates 2^LOG2_AVG consecutive same-channel samples and emits the window average, minimum and maximum on a valid/ready output port.
- Feeds the display/threshold logic, so raw single-conversion noise never reaches it.

Parameters:
- DATA_W, 12, sample width in bits (ADC resolution).
- CH_W, 3, channel tag width (matches the 3-bit channel select).
- LOG2_AVG, 4, log2 of window length; window = 16 samples; legal range 1..8.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  one-cycle strobe: in_data/in_ch valid this cycle; no ready, never stalled.
- in_data  in  DATA_W  unsigned ADC sample.
- in_ch  in  CH_W  channel the sample was converted on.
- clear  in  1  synchronous: abandon the partial window; output register untouched.
- out_valid  out  1  result held and available.
- out_ready  in  1  consumer accepts the result when out_valid && out_ready.
- out_avg  out  DATA_W  window average.
- out_min  out  DATA_W  window minimum.
- out_max  out  DATA_W  window maximum.
- out_ch  out  CH_W  channel of the window.
- restart  out  1  one-cycle pulse: partial window discarded by a channel change.
- overrun  out  1  sticky: a completed window was dropped; cleared only by rst.

Behaviour:
- Reset, async on rst high:
  - FSM enters IDLE.
  - acc, cnt, cur_ch and all out_* registers go to 0; restart and overrun go to 0.
- Internal registers:
  - acc, width DATA_W+LOG2_AVG; never overflows (full scale 0xFFF*16 = 0xFFF0 fits in 16 bits).
  - cnt, width LOG2_AVG+1.
  - cur_ch, run_min, run_max.
- FSM states:
  - IDLE, waiting for the first sample of a window.
  - ACCUM, window in progress.
- IDLE, on in_valid:
  - acc = in_data, run_min = run_max = in_data, cur_ch = in_ch, cnt = 1; go to ACCUM.
- ACCUM, on in_valid with in_ch == cur_ch:
  - acc += in_data, run_min/run_max updated, cnt += 1.
- ACCUM, on in_valid with in_ch != cur_ch:
  - Partial window discarded; restart pulses high for 1 cycle.
  - The new sample starts a fresh window: acc = in_data, cnt = 1, cur_ch = in_ch; stay in ACCUM.
- Window complete: the in_valid that brings cnt to 2^LOG2_AVG.
  - Final sum, min and max include that sample, computed combinationally.
  - On that same clock edge the result is loaded into the output registers (if permitted, see below) and the FSM returns to IDLE.
  - Latency: out_valid is high in the cycle immediately after the final sample's cycle.
- Result arithmetic:
  - out_avg = final_sum >> LOG2_AVG, truncating, no rounding.
  - out_min and out_max are exact.
  - out_ch = cur_ch.
- Output handshake:
  - out_* are stable while out_valid && !out_ready.
  - A transfer occurs on an edge where out_valid && out_ready; out_valid drops the next cycle unless a new result loads on the same edge.
  - If a window completes while out_valid && !out_ready: new result dropped, old result kept, overrun set (sticky).
  - If a window completes on the same edge out_ready accepts the old result: new result loads and out_valid stays high, no gap; not an overrun.
- clear:
  - Forces IDLE and cnt = 0.
  - If clear and in_valid coincide, clear wins and the sample is discarded.
  - clear does not affect out_valid, out_* or overrun.
- Stall tolerance:
  - in_valid may be separated by any number of idle cycles; the accumulator holds state between samples.
  - Back-to-back in_valid every cycle is supported.
- Mid-operation reset: rst asserted anywhere aborts immediately, with all state and outputs as at reset; the first in_valid after release starts a new window.

Test Plan:
- 16 back-to-back samples of 0x100 on ch 2, out_ready = 1 -> out_valid one cycle after the 16th sample; avg = min = max = 0x100, out_ch = 2, overrun = 0.
- Ramp 0..15 on ch 0, in_valid every 3rd cycle -> avg = 7 (120 >> 4), min = 0, max = 15.
- 16 samples of 0xFFF -> avg = 0xFFF, max = 0xFFF; no accumulator wrap.
- 5 samples on ch 1, then 16 samples on ch 3 -> restart pulse on the 6th sample; one result with out_ch = 3 and averages taken over ch-3 data only.
- out_ready = 0, two full windows (values 0x010 then 0x020) -> out_avg stays 0x010; overrun = 1 after the second window. Then out_ready = 1 -> 0x010 accepted, out_valid drops.
- rst pulsed after 8 samples, then 16 samples of 0x080 -> all outputs 0 during reset; a single result of 0x080. A clear coincident with a sample -> that sample excluded from the count.
